// File: rtl/display_pkg.sv
// Shared codes, FSM encoding and digit mapping for the seven-segment display arbiter.
// Optional leading-zero blanking of numeric digits is enabled with DISPLAY_LZB_EN.
package display_pkg;

  localparam int unsigned VAL_W = 8;
  localparam int unsigned BCD_W = 12;
  localparam int unsigned DIG_W = 16;

  typedef logic [3:0] bcd_digit_t;

  typedef enum logic [1:0] {
    SRC_BPM = 2'd0,
    SRC_VOL = 2'd1,
    SRC_ERR = 2'd2
  } src_e;

  localparam bcd_digit_t TAG_VOL = 4'hA;
  localparam bcd_digit_t TAG_ERR = 4'hE;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LOAD   = 2'd1,
    ST_CONV   = 2'd2,
    ST_COMMIT = 2'd3
  } state_e;

  typedef struct packed {
    logic [DIG_W-1:0] dig;
    logic [3:0]       blank;
  } disp_t;

  // Builds the four digit nibbles and blanking flags for one committed source.
  function automatic disp_t map_digits(input src_e src, input bcd_digit_t code,
                                       input logic [BCD_W-1:0] bcd);
    disp_t      d;
    logic [2:0] lzb;
    lzb = 3'b000;
`ifdef DISPLAY_LZB_EN
    lzb[2] = (bcd[11:8] == 4'h0);
    lzb[1] = lzb[2] && (bcd[7:4] == 4'h0);
`endif
    case (src)
      SRC_ERR: begin
        d.dig   = {TAG_ERR, 8'h00, code};
        d.blank = 4'b0110;
      end
      SRC_VOL: begin
        d.dig   = {TAG_VOL, bcd};
        d.blank = {1'b0, lzb};
      end
      default: begin
        d.dig   = {4'h0, bcd};
        d.blank = {1'b1, lzb};
      end
    endcase
    return d;
  endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Sequential 8-bit binary to 3-digit BCD converter (shift-add-3, 8 iterations).
module bin2bcd_seq
  import display_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [VAL_W-1:0] bin,
  output logic             done,
  output logic [BCD_W-1:0] bcd
);

  localparam int unsigned SR_W  = BCD_W + VAL_W;
  localparam int unsigned CNT_W = 3;

  logic [SR_W-1:0]  sr;
  logic [SR_W-1:0]  adj_c;
  logic [CNT_W-1:0] cnt;

  // Add 3 to every BCD nibble that is 5 or more before the next shift.
  always_comb begin
    adj_c = sr;
    for (int unsigned i = 0; i < 3; i++) begin
      if (sr[VAL_W+4*i +: 4] >= 4'd5) adj_c[VAL_W+4*i +: 4] = sr[VAL_W+4*i +: 4] + 4'd3;
    end
  end

  // The first iteration is folded into the load: add-3 is a no-op on an all-zero BCD field.
  always_ff @(posedge clk) begin
    if (rst) begin
      sr   <= '0;
      cnt  <= '0;
      done <= 1'b0;
    end else if (start) begin
      sr   <= {{(BCD_W-1){1'b0}}, bin, 1'b0};
      cnt  <= CNT_W'(VAL_W - 1);
      done <= 1'b0;
    end else if (cnt != '0) begin
      sr   <= {adj_c[SR_W-2:0], 1'b0};
      cnt  <= cnt - CNT_W'(1);
      done <= (cnt == CNT_W'(1));
    end else begin
      done <= 1'b0;
    end
  end

  assign bcd = sr[SR_W-1 -: BCD_W];

endmodule

// File: rtl/display_arbiter.sv
// Selects error/volume/BPM for the 4-digit display, converts to BCD and commits digits.
// Leading-zero blanking of numeric digits is enabled with DISPLAY_LZB_EN.
module display_arbiter
  import display_pkg::*;
#(
  parameter int unsigned HOLD_CYCLES    = 50_000_000,
  parameter int unsigned REFRESH_CYCLES = 500_000
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic [VAL_W-1:0] BPM,
  input  logic [VAL_W-1:0] VOL,
  input  logic             VOL_UPD,
  input  logic             ERR_VALID,
  input  logic [3:0]       ERR_CODE,
  output logic [DIG_W-1:0] DIG_BCD,
  output logic [3:0]       DIG_BLANK,
  output logic [1:0]       SRC,
  output logic             UPD
);

  localparam int unsigned HOLD_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam int unsigned REF_W  = (REFRESH_CYCLES > 1) ? $clog2(REFRESH_CYCLES) : 1;

  state_e           state, state_nx;
  logic [HOLD_W-1:0] hold_cnt;
  logic [REF_W-1:0]  ref_cnt;
  logic              pending;
  src_e              lat_src;
  logic [VAL_W-1:0]  lat_val;

  src_e              sel_src_c;
  logic [VAL_W-1:0]  sel_val_c;
  logic              wrap_c;
  logic              event_c;
  logic              load_c;
  logic              commit_c;
  logic              conv_done;
  logic [BCD_W-1:0]  conv_bcd;
  disp_t             disp_c;

  // Priority: error, then volume while the hold timer runs, else BPM.
  always_comb begin
    sel_src_c = SRC_BPM;
    sel_val_c = BPM;
    if (ERR_VALID) begin
      sel_src_c = SRC_ERR;
      sel_val_c = {4'h0, ERR_CODE};
    end else if (hold_cnt != '0) begin
      sel_src_c = SRC_VOL;
      sel_val_c = VOL;
    end
  end

  // A change seen during LOAD is already captured by that same latch.
  assign wrap_c  = (ref_cnt == REF_W'(REFRESH_CYCLES - 1));
  assign event_c = wrap_c ||
                   (!load_c && ((sel_src_c != lat_src) || (sel_val_c != lat_val)));

  always_ff @(posedge CLK) begin
    if (RST) begin
      hold_cnt <= '0;
      ref_cnt  <= '0;
      pending  <= 1'b1;
      lat_src  <= SRC_BPM;
      lat_val  <= '0;
    end else begin
      if (VOL_UPD)                hold_cnt <= HOLD_W'(HOLD_CYCLES - 1);
      else if (hold_cnt != '0)    hold_cnt <= hold_cnt - HOLD_W'(1);
      ref_cnt <= wrap_c ? '0 : ref_cnt + REF_W'(1);
      if (event_c)     pending <= 1'b1;
      else if (load_c) pending <= 1'b0;
      if (load_c) begin
        lat_src <= sel_src_c;
        lat_val <= sel_val_c;
      end
    end
  end

  // FSM state register.
  always_ff @(posedge CLK) begin
    if (RST) state <= ST_IDLE;
    else     state <= state_nx;
  end

  // FSM next state; CONV length is set by the converter finishing.
  always_comb begin
    state_nx = state;
    case (state)
      ST_IDLE:   if (pending) state_nx = ST_LOAD;
      ST_LOAD:   state_nx = ST_CONV;
      ST_CONV:   if (conv_done) state_nx = ST_COMMIT;
      ST_COMMIT: state_nx = ST_IDLE;
      default:   state_nx = ST_IDLE;
    endcase
  end

  // FSM control strobes.
  always_comb begin
    load_c   = 1'b0;
    commit_c = 1'b0;
    case (state)
      ST_LOAD: load_c   = 1'b1;
      ST_CONV: commit_c = conv_done;
      default: ;
    endcase
  end

  bin2bcd_seq u_bin2bcd (
    .clk   (CLK),
    .rst   (RST),
    .start (load_c),
    .bin   (sel_val_c),
    .done  (conv_done),
    .bcd   (conv_bcd)
  );

  assign disp_c = map_digits(lat_src, lat_val[3:0], conv_bcd);

  // Outputs load on the last CONV cycle so UPD is visible during COMMIT.
  always_ff @(posedge CLK) begin
    if (RST) begin
      DIG_BCD   <= '0;
      DIG_BLANK <= 4'b1111;
      SRC       <= 2'd0;
      UPD       <= 1'b0;
    end else begin
      UPD <= commit_c;
      if (commit_c) begin
        DIG_BCD   <= disp_c.dig;
        DIG_BLANK <= disp_c.blank;
        SRC       <= lat_src;
      end
    end
  end

endmodule

// File: doc/display_arbiter.md
Name: display_arbiter

Overview:
Controller for the 4-digit seven-segment display path. It arbitrates which value the display shows among three sources: BPM, volume and error code. Priority is error > volume (time-limited hold after each update) > BPM. The selected 8-bit value is converted to BCD with a sequential double-dabble unit, and the block presents four digit nibbles plus blanking flags to the segment driver/scanner.

Parameters:
HOLD_CYCLES, 50_000_000, cycles volume stays displayed after the last VOL_UPD (1 s at 50 MHz)
REFRESH_CYCLES, 500_000, period of forced re-conversion of the selected source (10 ms)

Ports:
CLK  in  1  system clock; single clock domain
RST  in  1  synchronous, active-high reset
BPM  in  8  current tempo, unsigned
VOL  in  8  current volume, unsigned
VOL_UPD  in  1  one-cycle pulse; volume changed, (re)start hold
ERR_VALID  in  1  level; error present
ERR_CODE  in  4  error number
DIG_BCD  out  16  digit nibbles; [15:12]=digit3 (leftmost) ... [3:0]=digit0
DIG_BLANK  out  4  bit i=1 blanks digit i
SRC  out  2  committed source: 0=BPM, 1=VOL, 2=ERR
UPD  out  1  one-cycle pulse when DIG_BCD/DIG_BLANK/SRC change

Behaviour:
- Interface: one clock CLK; RST is synchronous and active-high.
- Reset values: DIG_BCD=16'h0000, DIG_BLANK=4'b1111, SRC=0, UPD=0, hold counter=0, refresh counter=0, FSM=IDLE, pending=1. The first conversion therefore starts on the first cycle after reset.
- Source selection is combinational: ERR if ERR_VALID; else VOL if hold_cnt!=0; else BPM.
- Hold counter: VOL_UPD loads HOLD_CYCLES-1. Otherwise it decrements to 0 and saturates there. VOL_UPD while the counter is nonzero reloads it.
- Pending flag is set when any of these holds:
  - the selected source differs from the last latched source;
  - the selected value differs from the last latched value;
  - the refresh counter wraps at REFRESH_CYCLES-1.
- Pending is cleared in LOAD. Events arriving during LOAD/CONV/COMMIT set pending again and are serviced after COMMIT. Multiple events coalesce into one conversion.
- FSM:
  - IDLE -> LOAD when pending.
  - LOAD: latch source and value (ERR uses {4'h0,ERR_CODE}); start bin2bcd_seq.
  - CONV: exactly 8 cycles.
  - COMMIT: register outputs and assert UPD for 1 cycle, then go to IDLE.
  - Latency from pending seen in IDLE to UPD is 10 cycles.
- Digit mapping:
  - BPM: digit3 blank, digits2..0 = BCD hundreds/tens/ones.
  - VOL: digit3 = 4'hA (volume tag), digits2..0 = BCD.
  - ERR: digit3 = 4'hE, digits2..1 blank, digit0 = ERR_CODE.
- Max value 255 gives a hundreds digit of 2 at most. There is no overflow path.
- RST asserted in any state aborts the conversion and restores the reset values next cycle. The converter is also reset.
- ERR_VALID dropping mid-conversion: the current result still commits, then pending triggers a re-conversion of the new source.

Optional Feature:
DISPLAY_LZB_EN: leading-zero blanking on numeric digits. Digit2 is blanked if its value is 0. Digit1 is blanked if digit2 and digit1 are both 0. Digit0 is never blanked. Without the macro, numeric digits2..0 are always shown. Tag/ERR blanking is unaffected.

Decomposition:
- display_pkg: SRC_BPM/SRC_VOL/SRC_ERR codes, TAG_VOL=4'hA, TAG_ERR=4'hE, FSM state encoding, BCD digit typedef.
- Sub-module bin2bcd_seq (start, 8-bit in, done, 12-bit BCD out; shift-add-3, 8 iterations).
- Timers and FSM stay in display_arbiter.

Test Plan:
(bench overrides HOLD_CYCLES=20, REFRESH_CYCLES=50)
1. RST then BPM=120 -> UPD within 10 cycles of reset release; DIG_BCD=16'h0120, DIG_BLANK=4'b1000, SRC=0.
2. BPM=7 -> DIG_BCD=16'h0007; DIG_BLANK=4'b1110 with DISPLAY_LZB_EN, 4'b1000 without.
3. VOL=45, single VOL_UPD pulse -> SRC=1, DIG_BCD=16'hA045, DIG_BLANK=4'b0100 (LZB on). 20 cycles after the pulse the display reverts to SRC=0 showing BPM. A second pulse at cycle 15 extends the hold to cycle 35.
4. ERR_VALID=1, ERR_CODE=3 during volume hold -> SRC=2, DIG_BCD=16'hE003, DIG_BLANK=4'b0110. Deassert before hold expiry -> SRC=1.
5. BPM changed 4 times during CONV -> exactly one further UPD after COMMIT, showing the final BPM. With inputs stable, UPD recurs every REFRESH period only.
6. RST pulsed mid-CONV -> next cycle outputs equal reset values and UPD=0. The first conversion completes 10 cycles after RST deasserts.
